error_round_feeder: RTL and testbench
=====================================

Name: error_round_feeder

Overview:
- Sits directly downstream of the per-channel error_stream generators.
- Waits until every channel reports a complete error frame (MEASUREMENT_ROUNDS bits each), captures all frames in one cycle and pulses update_errors so the generators refill in the background.
- Streams the captured frame to the decoder one measurement round per handshake: one bit per channel per round.
- Runs a programmed number of frames, or continuously until stopped.

Parameters:
- MEASUREMENT_ROUNDS, 5: rounds per frame; bits per channel stream.
- NUM_CHANNELS, 4: number of error_stream instances feeding this block.
- ROUND_W, $clog2(MEASUREMENT_ROUNDS) (min 1): width of round_index.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a run. Ignored while busy.
- stop  input  1  level; ends a run at the next frame boundary.
- frame_count  input  16  frames to run, sampled on start; 0 = continuous.
- update_valid  input  NUM_CHANNELS  per-channel frame-ready flags from the generators.
- error_streams  input  NUM_CHANNELS*MEASUREMENT_ROUNDS  channel c stream = [c*MEASUREMENT_ROUNDS +: MEASUREMENT_ROUNDS].
- update_errors  output  1  broadcast to all generators; frame consumed, generate next.
- round_bits  output  NUM_CHANNELS  bit c = channel c error bit for the current round.
- round_valid  output  1  round_bits, round_index and last_round are valid.
- round_ready  input  1  decoder accepts the round.
- round_index  output  ROUND_W  current round, 0..MEASUREMENT_ROUNDS-1.
- last_round  output  1  round_index == MEASUREMENT_ROUNDS-1 while round_valid.
- frame_id  output  16  index of the frame being streamed; cleared on start; wraps at 2^16.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse when a counted or stopped run ends.

Behaviour:
- Reset:
  - state = IDLE.
  - All outputs 0, including update_errors, round_bits, round_valid, round_index, frame_id and done.
  - Capture buffer and frame counter cleared.
  - Reset mid-frame discards the frame; no done pulse.
- States: IDLE, WAIT, STREAM.
- IDLE, on start:
  - frames_left <= frame_count; continuous = (frame_count == 0); frame_id <= 0.
  - Next state WAIT.
- WAIT:
  - When stop is high: go to IDLE and pulse done next cycle. update_errors is not asserted. Stop takes priority over capture in the same cycle.
  - Otherwise, when all update_valid bits are 1 in the same cycle:
    - update_errors = 1 for exactly that cycle; it is combinational from state and &update_valid.
    - buffer <= error_streams.
    - round_index <= 0; next state STREAM.
  - A partial update_valid (some bits 1) keeps the block in WAIT; nothing is captured.
- STREAM:
  - round_valid = 1.
  - round_bits[c] = buffer[c*MEASUREMENT_ROUNDS + round_index].
  - round_bits, round_index and last_round stay stable while round_valid && !round_ready.
  - On round_valid && round_ready with round_index < MEASUREMENT_ROUNDS-1: round_index increments; throughput is 1 round/cycle while ready stays high.
  - On the handshake with last_round, the frame completes:
    - frame_id increments.
    - If !continuous: frames_left decrements. If it reaches 0, go to IDLE and pulse done.
    - If continuous and stop is high that cycle, go to IDLE and pulse done.
    - Otherwise go to WAIT.
  - A stop asserted mid-frame does not truncate the frame; it is honoured at the frame's last handshake if still high then. It is also honoured in WAIT.
- update_errors is never asserted outside WAIT. This gives at most one pulse per captured frame, so the generators are never double-advanced.
- Minimum frame period is MEASUREMENT_ROUNDS + 1 cycles: MEASUREMENT_ROUNDS stream cycles plus one WAIT cycle, when the generators are already valid.
- done is registered and asserted one cycle after the terminating transition; busy is low in that same cycle.
- start while busy is ignored; frame_count is not resampled.

Test Plan:
1. NUM_CHANNELS=4, MEASUREMENT_ROUNDS=5, streams 5'b00001, 5'b00010, 5'b10000, 5'b00000, all valid; start with frame_count=1, ready held high.
   - update_errors pulses exactly once.
   - round_bits = 4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0100 for round_index 0..4.
   - last_round is high only on round 4.
   - done pulses once; busy falls.
2. Backpressure: toggle round_ready 1010..., as in scenario 1.
   - Outputs stay stable across stalls.
   - Each round is accepted exactly once, in order.
   - Total rounds accepted = 5.
3. Staggered update_valid: channels assert at cycles 3, 7, 7, 12 after start.
   - Capture and update_errors occur only at cycle 12.
   - Buffer equals error_streams at that cycle.
4. frame_count=0 (continuous), generators always valid:
   - 3 frames stream back-to-back with frame_id 0, 1, 2.
   - stop raised mid-frame 2 lets frame 2 finish, then IDLE with done.
   - update_errors pulses exactly 3 times.
5. stop while in WAIT: block goes to IDLE, done pulses, and update_errors stays 0.
6. Reset mid-STREAM at round_index=2:
   - Next cycle all outputs are 0, state is IDLE and there is no done pulse.
   - A subsequent start runs normally from frame_id=0.

Source files
------------

// File: rtl/error_round_feeder.sv
// Captures one complete error frame from all channels, then streams it one measurement round per handshake.
// Latency: one WAIT cycle at minimum before streaming. Backpressure: round outputs hold while round_ready is low.
module error_round_feeder #(
    parameter int MEASUREMENT_ROUNDS = 5,
    parameter int NUM_CHANNELS       = 4,
    parameter int ROUND_W            = (MEASUREMENT_ROUNDS > 1) ? $clog2(MEASUREMENT_ROUNDS) : 1
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic                                       stop,
    input  logic [15:0]                                frame_count,
    input  logic [NUM_CHANNELS-1:0]                    update_valid,
    input  logic [NUM_CHANNELS*MEASUREMENT_ROUNDS-1:0] error_streams,
    output logic                                       update_errors,
    output logic [NUM_CHANNELS-1:0]                    round_bits,
    output logic                                       round_valid,
    input  logic                                       round_ready,
    output logic [ROUND_W-1:0]                         round_index,
    output logic                                       last_round,
    output logic [15:0]                                frame_id,
    output logic                                       busy,
    output logic                                       done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    localparam int                 BUF_W    = NUM_CHANNELS * MEASUREMENT_ROUNDS;
    localparam logic [ROUND_W-1:0] LAST_IDX = ROUND_W'(MEASUREMENT_ROUNDS - 1);

    logic [1:0]         state_q, state_d;
    logic [BUF_W-1:0]   buffer_q, buffer_d;
    logic [ROUND_W-1:0] round_index_q, round_index_d;
    logic [15:0]        frames_left_q, frames_left_d;
    logic               continuous_q, continuous_d;
    logic [15:0]        frame_id_q, frame_id_d;
    logic               done_q, done_d;

    logic all_valid;
    logic handshake;

    assign all_valid   = &update_valid;
    assign round_valid = (state_q == S_STREAM);
    assign handshake   = round_valid && round_ready;
    assign round_index = round_index_q;
    assign last_round  = round_valid && (round_index_q == LAST_IDX);
    assign frame_id    = frame_id_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;

    // Each channel's stream occupies a contiguous slice; pick this round's bit from every slice.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_round_bits
        logic [MEASUREMENT_ROUNDS-1:0] chan;
        assign chan          = buffer_q[c*MEASUREMENT_ROUNDS +: MEASUREMENT_ROUNDS];
        assign round_bits[c] = round_valid & chan[round_index_q];
    end

    always_comb begin
        state_d       = state_q;
        buffer_d      = buffer_q;
        round_index_d = round_index_q;
        frames_left_d = frames_left_q;
        continuous_d  = continuous_q;
        frame_id_d    = frame_id_q;
        done_d        = 1'b0;
        update_errors = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    frames_left_d = frame_count;
                    continuous_d  = (frame_count == 16'd0);
                    frame_id_d    = 16'd0;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                // Stop wins over capture so a stopped run never advances the generators.
                if (stop) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (all_valid) begin
                    update_errors = 1'b1;
                    buffer_d      = error_streams;
                    round_index_d = '0;
                    state_d       = S_STREAM;
                end
            end
            S_STREAM: begin
                if (handshake) begin
                    if (round_index_q != LAST_IDX) begin
                        round_index_d = round_index_q + 1'b1;
                    end else begin
                        frame_id_d    = frame_id_q + 16'd1;
                        round_index_d = '0;
                        if (!continuous_q) begin
                            frames_left_d = frames_left_q - 16'd1;
                            if (frames_left_q == 16'd1) begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = S_WAIT;
                            end
                        end else if (stop) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            buffer_q      <= '0;
            round_index_q <= '0;
            frames_left_q <= '0;
            continuous_q  <= 1'b0;
            frame_id_q    <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            buffer_q      <= buffer_d;
            round_index_q <= round_index_d;
            frames_left_q <= frames_left_d;
            continuous_q  <= continuous_d;
            frame_id_q    <= frame_id_d;
            done_q        <= done_d;
        end
    end

endmodule

// File: tb/tb_error_round_feeder.sv
// Bench for error_round_feeder: table of frames plus hand-written stop/stagger/reset sequences.
module tb_error_round_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic [15:0] frame_count;
    logic [3:0]  update_valid;
    logic [19:0] error_streams;
    logic        update_errors;
    logic [3:0]  round_bits;
    logic        round_valid;
    logic        round_ready;
    logic [2:0]  round_index;
    logic        last_round;
    logic [15:0] frame_id;
    logic        busy;
    logic        done;

    error_round_feeder #(.MEASUREMENT_ROUNDS(5), .NUM_CHANNELS(4)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .frame_count(frame_count),
        .update_valid(update_valid), .error_streams(error_streams), .update_errors(update_errors),
        .round_bits(round_bits), .round_valid(round_valid), .round_ready(round_ready),
        .round_index(round_index), .last_round(last_round), .frame_id(frame_id),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] streams;
        logic [19:0] exp;      // round r bits at [r*4 +: 4]
        int          nframes;
        bit          tog;
    } vec_t;

    typedef struct {
        logic [3:0]  bits;
        logic [2:0]  idx;
        logic        last;
        logic [15:0] fid;
    } rec_t;

    vec_t vecs[4];
    rec_t sb_q[$];

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    int done_cnt = 0;
    int hs_cnt = 0;
    bit sb_en = 1'b1;
    bit ready_mode = 1'b0;

    bit         held_vld = 1'b0;
    logic [3:0] held_bits;
    logic [2:0] held_idx;
    logic       held_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] pack_exp(input logic [19:0] s);
        logic [19:0] e;
        e = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 4; c++)
                e[r*4 + c] = s[c*5 + r];
        return e;
    endfunction

    task automatic push_frame(input logic [19:0] exp, input logic [15:0] fid);
        rec_t rec;
        for (int r = 0; r < 5; r++) begin
            rec.bits = exp[r*4 +: 4];
            rec.idx  = 3'(r);
            rec.last = (r == 4);
            rec.fid  = fid;
            sb_q.push_back(rec);
        end
    endtask

    // Monitor: sampled on the falling edge, halfway between active edges.
    always @(negedge clk) begin
        if (!reset) begin
            if (update_errors) upd_cnt++;
            if (done) done_cnt++;
            if (held_vld) begin
                check("stall_valid", 32'(round_valid), 32'd1);
                check("stall_bits", 32'(round_bits), 32'(held_bits));
                check("stall_idx", 32'(round_index), 32'(held_idx));
                check("stall_last", 32'(last_round), 32'(held_last));
            end
            held_vld  = round_valid && !round_ready;
            held_bits = round_bits;
            held_idx  = round_index;
            held_last = last_round;
            if (round_valid && round_ready) begin
                hs_cnt++;
                if (sb_en) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_underflow: unexpected round idx %0d bits %0h", round_index, round_bits);
                    end else begin
                        rec_t e;
                        e = sb_q.pop_front();
                        check("round_bits", 32'(round_bits), 32'(e.bits));
                        check("round_index", 32'(round_index), 32'(e.idx));
                        check("last_round", 32'(last_round), 32'(e.last));
                        check("frame_id", 32'(frame_id), 32'(e.fid));
                    end
                end
            end
        end else begin
            held_vld = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) round_ready = ~round_ready;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) check({name, "_busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input int i);
        int u0, d0, h0;
        for (int f = 0; f < vecs[i].nframes; f++) push_frame(vecs[i].exp, 16'(f));
        u0 = upd_cnt; d0 = done_cnt; h0 = hs_cnt;
        round_ready   = 1'b1;
        ready_mode    = vecs[i].tog;
        frame_count   = 16'(vecs[i].nframes);
        error_streams = vecs[i].streams;
        update_valid  = 4'hf;
        pulse_start();
        // A second start while busy must not reload the frame counter.
        repeat (2) @(posedge clk);
        #1;
        frame_count = 16'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(200, $sformatf("vec%0d", i));
        ready_mode  = 1'b0;
        round_ready = 1'b1;
        check($sformatf("vec%0d_upd", i), 32'(upd_cnt - u0), 32'(vecs[i].nframes));
        check($sformatf("vec%0d_hs", i), 32'(hs_cnt - h0), 32'(5 * vecs[i].nframes));
        check($sformatf("vec%0d_done", i), 32'(done_cnt - d0), 32'd1);
        check($sformatf("vec%0d_sb_empty", i), 32'(sb_q.size()), 32'd0);
        check($sformatf("vec%0d_fid_end", i), 32'(frame_id), 32'(vecs[i].nframes));
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int u0, d0, h0;
        logic [19:0] cap;
        bit found;

        vecs[0] = '{20'b00000_10000_00010_00001, {4'b0100, 4'b0000, 4'b0000, 4'b0010, 4'b0001}, 1, 1'b0};
        vecs[1] = '{20'b00000_10000_00010_00001, {4'b0100, 4'b0000, 4'b0000, 4'b0010, 4'b0001}, 1, 1'b1};
        vecs[2] = '{20'hfffff, 20'hfffff, 2, 1'b0};
        vecs[3] = '{20'b00111_11000_01010_10101, {4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1001}, 1, 1'b1};

        reset = 1'b1; start = 1'b0; stop = 1'b0; frame_count = '0;
        update_valid = 4'hf; error_streams = 20'hfffff; round_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_update_errors", 32'(update_errors), 32'd0);
        check("rst_round_valid", 32'(round_valid), 32'd0);
        check("rst_round_bits", 32'(round_bits), 32'd0);
        check("rst_round_index", 32'(round_index), 32'd0);
        check("rst_frame_id", 32'(frame_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) run_vec(i);

        // Staggered channel readiness: capture only once every channel is valid.
        u0 = upd_cnt; d0 = done_cnt;
        update_valid = 4'h0;
        frame_count  = 16'd1;
        pulse_start();
        cap = '0;
        for (int k = 1; k <= 12; k++) begin
            update_valid  = {k >= 12, k >= 7, k >= 7, k >= 3};
            error_streams = 20'($urandom);
            @(negedge clk);
            check($sformatf("stagger_upd_k%0d", k), 32'(update_errors), 32'(k == 12));
            if (k == 12) begin
                cap = error_streams;
                push_frame(pack_exp(cap), 16'd0);
            end
            @(posedge clk); #1;
        end
        error_streams = ~cap;
        wait_done(100, "stagger");
        check("stagger_upd", 32'(upd_cnt - u0), 32'd1);
        check("stagger_sb_empty", 32'(sb_q.size()), 32'd0);
        sb_q.delete();

        // Continuous run, stop raised mid frame 2.
        u0 = upd_cnt; d0 = done_cnt; h0 = hs_cnt;
        error_streams = 20'h5a3c9;
        update_valid  = 4'hf;
        frame_count   = 16'd0;
        for (int f = 0; f < 3; f++) push_frame(pack_exp(20'h5a3c9), 16'(f));
        pulse_start();
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (round_valid && frame_id == 16'd2 && round_index == 3'd2) begin
                found = 1'b1;
                break;
            end
        end
        check("cont_reach_f2", 32'(found), 32'd1);
        stop = 1'b1;
        wait_done(50, "cont");
        stop = 1'b0;
        check("cont_upd", 32'(upd_cnt - u0), 32'd3);
        check("cont_hs", 32'(hs_cnt - h0), 32'd15);
        check("cont_done", 32'(done_cnt - d0), 32'd1);
        check("cont_fid_end", 32'(frame_id), 32'd3);
        check("cont_sb_empty", 32'(sb_q.size()), 32'd0);
        sb_q.delete();

        // Stop while waiting on generators.
        u0 = upd_cnt; d0 = done_cnt;
        update_valid = 4'h0;
        frame_count  = 16'd3;
        pulse_start();
        repeat (3) @(posedge clk);
        #1;
        check("waitstop_busy", 32'(busy), 32'd1);
        update_valid = 4'hf;
        stop = 1'b1;
        wait_done(20, "waitstop");
        stop = 1'b0;
        check("waitstop_upd", 32'(upd_cnt - u0), 32'd0);
        check("waitstop_done", 32'(done_cnt - d0), 32'd1);

        // Reset in the middle of the second frame of a two-frame run.
        sb_en = 1'b0;
        error_streams = vecs[0].streams;
        update_valid  = 4'hf;
        frame_count   = 16'd2;
        pulse_start();
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (round_valid && frame_id == 16'd1 && round_index == 3'd2) begin
                found = 1'b1;
                break;
            end
        end
        check("rstmid_reach", 32'(found), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rstmid_round_valid", 32'(round_valid), 32'd0);
        check("rstmid_round_bits", 32'(round_bits), 32'd0);
        check("rstmid_round_index", 32'(round_index), 32'd0);
        check("rstmid_last", 32'(last_round), 32'd0);
        check("rstmid_update_errors", 32'(update_errors), 32'd0);
        check("rstmid_frame_id", 32'(frame_id), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check($sformatf("rstmid_no_done_%0d", n), 32'(done), 32'd0);
        end
        sb_q.delete();
        sb_en = 1'b1;
        run_vec(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
